bv_scan: RTL and testbench
==========================

BV_SCAN -- requirements
Module: bv_scan

Interface
REQ-001 Parameter WIDTH, default 64: bit-vector width in bits, range 2..256.
REQ-002 Parameter WIDTH_COUNT, default 6: index width, equal to clog2(WIDTH).
REQ-003 Parameter MAX_HITS, default 8: maximum indices emitted per vector, range 1..WIDTH.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bv_valid  input  1  upstream vector valid.
REQ-007 bv_ready  output  1  block can accept a vector this cycle.
REQ-008 bv  input  WIDTH  bit vector; bit 0 is the lowest index.
REQ-009 idx_valid  output  1  idx beat valid.
REQ-010 idx_ready  input  1  downstream accepts the idx beat.
REQ-011 idx  output  WIDTH_COUNT  position of the lowest remaining set bit.
REQ-012 idx_last  output  1  the current beat is the final beat for this vector.
REQ-013 idx_none  output  1  the accepted vector was all-zero.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-015 In IDLE: bv_ready=1 and idx_valid=0.
REQ-016 In IDLE with bv_valid=1: latch bv into the work register, clear the hit counter, enter SCAN.
REQ-017 In SCAN: bv_ready=0 and idx_valid=1.
REQ-018 The first beat SHALL appear in the cycle after acceptance (latency 1).
REQ-019 idx SHALL be the lowest set bit of the work register.
REQ-020 idx/idx_valid/idx_last/idx_none SHALL depend only on registered state, with no combinational path from any input.
REQ-021 A beat transfers when idx_valid=1 and idx_ready=1.
REQ-022 On transfer: clear that bit in the work register and increment the hit counter.
REQ-023 While idx_valid=1 and idx_ready=0, all idx outputs SHALL hold stable.
REQ-024 idx_last=1 when the work register has exactly one set bit, or when the hit counter equals MAX_HITS-1.
REQ-025 All-zero vector: emit one beat with idx=0, idx_none=1, idx_last=1.
REQ-026 Transfer of the last beat returns the FSM to IDLE; bv_ready=1 in the next cycle.
REQ-027 Throughput SHALL be one index per cycle while idx_ready is held high.
REQ-028 Bits above the MAX_HITS-th set bit SHALL be discarded silently.
REQ-029 bv_valid in SCAN is ignored; the vector is not latched and not lost upstream (bv_ready=0).

Reset
REQ-030 On reset=1, asynchronously: FSM=IDLE, work register=0, hit counter=0, idx_valid=0, idx=0, idx_last=0, idx_none=0, bv_ready=1.
REQ-031 Reset asserted mid-SCAN SHALL abandon the vector with no further beats.
REQ-032 The first acceptance SHALL be possible on the first clock edge after reset deasserts.

Configuration
REQ-033 Macro BV_SCAN_COUNT_EN, when defined, adds output hit_total (WIDTH_COUNT+1 bits): popcount of the accepted vector, registered at acceptance and held for all beats of that vector.
REQ-034 Without BV_SCAN_COUNT_EN, hit_total and its popcount logic SHALL be absent, with all other behaviour identical.

Structure
REQ-035 Shared package bv_pkg SHALL hold the FSM state typedef and the clog2-based width helper constants.
REQ-036 One sub-module bv_prio_enc SHALL provide the combinational lowest-set-bit encoder (inputs: vector; outputs: index, any-set flag).

Verification
REQ-037 WIDTH=64, bv=0x0000_0000_0000_0092, idx_ready=1 -> idx 1,4,7 on consecutive cycles; idx_last only on 7; bv_ready=1 in the cycle after.
REQ-038 bv=0 -> single beat idx=0, idx_none=1, idx_last=1; then IDLE.
REQ-039 bv=0xFFFF, MAX_HITS=8 -> idx 0..7; idx_last on 7; bits 8..15 dropped.
REQ-040 bv=0x8000_0000_0000_0001, idx_ready low 3 cycles -> idx=0 held stable 3 cycles, then 0 and 63 delivered, with no loss or duplication.
REQ-041 reset pulsed during the second beat of bv=0x0F -> idx_valid=0 immediately and bv_ready=1; the next vector 0x10 yields a single beat idx=4 with idx_last=1.
REQ-042 With BV_SCAN_COUNT_EN, bv=0xF0F0 -> hit_total=8 on every beat.

Source files
------------

// File: rtl/bv_pkg.sv
// Shared types and width constants for the bit-vector index scanner.
package bv_pkg;

  localparam int unsigned BV_DEF_WIDTH       = 64;
  localparam int unsigned BV_DEF_WIDTH_COUNT = $clog2(BV_DEF_WIDTH);
  localparam int unsigned BV_DEF_MAX_HITS    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } bv_state_t;

endpackage

// File: rtl/bv_scan_if.sv
// Vector-in / index-out handshake bundle for bv_scan.
interface bv_scan_if
  import bv_pkg::*;
#(
  parameter int unsigned WIDTH       = BV_DEF_WIDTH,
  parameter int unsigned WIDTH_COUNT = BV_DEF_WIDTH_COUNT
);

  logic                   bv_valid;
  logic                   bv_ready;
  logic [WIDTH-1:0]       bv;
  logic                   idx_valid;
  logic                   idx_ready;
  logic [WIDTH_COUNT-1:0] idx;
  logic                   idx_last;
  logic                   idx_none;

  modport master (
    output bv_valid, bv, idx_ready,
    input  bv_ready, idx_valid, idx, idx_last, idx_none
  );

  modport slave (
    input  bv_valid, bv, idx_ready,
    output bv_ready, idx_valid, idx, idx_last, idx_none
  );

endinterface

// File: rtl/bv_prio_enc.sv
// Combinational lowest-set-bit encoder with an any-bit-set flag.
module bv_prio_enc #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned WIDTH_COUNT = 6
) (
  input  logic [WIDTH-1:0]       i_vec,
  output logic [WIDTH_COUNT-1:0] o_idx,
  output logic                   o_any
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    o_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = WIDTH_COUNT'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/bv_scan.sv
// Emits the indices of set bits of an accepted vector, lowest first, up to MAX_HITS.
// Optional BV_SCAN_COUNT_EN adds hit_total, the popcount of the accepted vector.
module bv_scan
  import bv_pkg::*;
#(
  parameter int unsigned WIDTH       = BV_DEF_WIDTH,
  parameter int unsigned WIDTH_COUNT = BV_DEF_WIDTH_COUNT,
  parameter int unsigned MAX_HITS    = BV_DEF_MAX_HITS
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef BV_SCAN_COUNT_EN
  output logic [WIDTH_COUNT:0]   hit_total,
`endif
  bv_scan_if.slave               bus
);

  localparam int unsigned CNT_W = WIDTH_COUNT + 1;

  bv_state_t              r_state;
  logic [WIDTH-1:0]       r_work;
  logic [WIDTH_COUNT-1:0] r_hits;
  logic                   r_none;
  logic                   r_bv_ready;
  logic                   r_idx_valid;
  logic [WIDTH_COUNT-1:0] r_idx;
  logic                   r_idx_last;

  bv_state_t              w_state_nxt;
  logic [WIDTH-1:0]       w_work_nxt;
  logic [WIDTH_COUNT-1:0] w_hits_nxt;
  logic                   w_none_nxt;
  logic [WIDTH_COUNT-1:0] w_enc_idx;
  logic                   w_enc_any;
  logic                   w_onehot;
  logic [WIDTH_COUNT-1:0] w_idx_nxt;
  logic                   w_last_nxt;

  // Encode the next work value so every index output can be registered.
  bv_prio_enc #(
    .WIDTH       (WIDTH),
    .WIDTH_COUNT (WIDTH_COUNT)
  ) u_enc (
    .i_vec (w_work_nxt),
    .o_idx (w_enc_idx),
    .o_any (w_enc_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_hits_nxt  = r_hits;
    w_none_nxt  = r_none;
    unique case (r_state)
      IDLE: begin
        if (bus.bv_valid) begin
          w_work_nxt  = bus.bv;
          w_hits_nxt  = '0;
          w_none_nxt  = (bus.bv == '0);
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (r_idx_valid && bus.idx_ready) begin
          if (r_idx_last) begin
            w_work_nxt  = '0;
            w_hits_nxt  = '0;
            w_none_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            // Clearing the lowest set bit retires the beat just transferred.
            w_work_nxt = r_work & (r_work - WIDTH'(1));
            w_hits_nxt = r_hits + WIDTH_COUNT'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_onehot   = w_enc_any && ((w_work_nxt & (w_work_nxt - WIDTH'(1))) == '0);
    w_idx_nxt  = (w_state_nxt == SCAN && w_enc_any) ? w_enc_idx : '0;
    w_last_nxt = (w_state_nxt == SCAN) &&
                 (w_none_nxt || w_onehot || (w_hits_nxt == WIDTH_COUNT'(MAX_HITS - 1)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_hits      <= '0;
      r_none      <= 1'b0;
      r_bv_ready  <= 1'b1;
      r_idx_valid <= 1'b0;
      r_idx       <= '0;
      r_idx_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_hits      <= w_hits_nxt;
      r_none      <= w_none_nxt;
      r_bv_ready  <= (w_state_nxt == IDLE);
      r_idx_valid <= (w_state_nxt == SCAN);
      r_idx       <= w_idx_nxt;
      r_idx_last  <= w_last_nxt;
    end
  end

  assign bus.bv_ready  = r_bv_ready;
  assign bus.idx_valid = r_idx_valid;
  assign bus.idx       = r_idx;
  assign bus.idx_last  = r_idx_last;
  assign bus.idx_none  = r_none;

`ifdef BV_SCAN_COUNT_EN
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] r_hit_total;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_pop = w_pop + CNT_W'(bus.bv[i]);
    end
  end

  // Captured only at acceptance so it stays put across all beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_total <= '0;
    end else if (r_state == IDLE && bus.bv_valid) begin
      r_hit_total <= w_pop;
    end
  end

  assign hit_total = r_hit_total;
`endif

endmodule

// File: tb/tb_bv_scan.sv
// Randomized self-checking bench for bv_scan against a set-bit-list reference model.
module tb_bv_scan;

  localparam int unsigned WIDTH       = 64;
  localparam int unsigned WIDTH_COUNT = 6;
  localparam int unsigned MAX_HITS    = 8;
  localparam int          BEAT_LIMIT  = 200;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  bv_scan_if #(.WIDTH(WIDTH), .WIDTH_COUNT(WIDTH_COUNT)) bus ();

`ifdef BV_SCAN_COUNT_EN
  logic [WIDTH_COUNT:0] hit_total;
`endif

  bv_scan #(
    .WIDTH       (WIDTH),
    .WIDTH_COUNT (WIDTH_COUNT),
    .MAX_HITS    (MAX_HITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef BV_SCAN_COUNT_EN
    .hit_total (hit_total),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called on a falling edge while the DUT is idle; mode 0 = always ready,
  // 1 = random ready plus junk upstream traffic, 2 = stall three cycles first.
  task automatic send_vec(input logic [63:0] v, input int mode);
    int   exp_q[$];
    bit   exp_none;
    int   k;
    int   cyc;
    logic rdy;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i] && exp_q.size() < int'(MAX_HITS)) exp_q.push_back(i);
    end
    exp_none = (exp_q.size() == 0);
    if (exp_none) exp_q.push_back(0);

    check("bv_ready_idle", 64'(bus.bv_ready), 64'(1));
    bus.bv       = v;
    bus.bv_valid = 1'b1;
    @(negedge clk);
    bus.bv_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < BEAT_LIMIT) begin
      check("idx_valid", 64'(bus.idx_valid), 64'(1));
      check("bv_ready_scan", 64'(bus.bv_ready), 64'(0));
      check("idx", 64'(bus.idx), 64'(exp_q[k]));
      check("idx_last", 64'(bus.idx_last), 64'(k == exp_q.size() - 1));
      check("idx_none", 64'(bus.idx_none), 64'(exp_none));
`ifdef BV_SCAN_COUNT_EN
      check("hit_total", 64'(hit_total), 64'($countones(v)));
`endif
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 3);
      endcase
      if (mode == 1) begin
        bus.bv_valid = 1'($urandom_range(0, 1));
        bus.bv       = {$urandom, $urandom};
      end
      bus.idx_ready = rdy;
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    check("beats_done", 64'(k), 64'(exp_q.size()));
    if (mode == 0) check("beat_cycles", 64'(cyc), 64'(exp_q.size()));
    bus.bv_valid  = 1'b0;
    bus.idx_ready = 1'b0;
    check("idx_valid_after", 64'(bus.idx_valid), 64'(0));
    check("bv_ready_after", 64'(bus.bv_ready), 64'(1));
  endtask

  initial begin
    logic [63:0] v;
    int          sel;
    n_total       = 0;
    n_bad         = 0;
    reset         = 1'b1;
    bus.bv_valid  = 1'b0;
    bus.bv        = '0;
    bus.idx_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_idx_valid", 64'(bus.idx_valid), 64'(0));
    check("rst_bv_ready", 64'(bus.bv_ready), 64'(1));
    check("rst_idx", 64'(bus.idx), 64'(0));
    check("rst_idx_last", 64'(bus.idx_last), 64'(0));
    check("rst_idx_none", 64'(bus.idx_none), 64'(0));

    reset = 1'b0;
    send_vec(64'h0000_0000_0000_0092, 0);
    send_vec(64'h0, 0);
    send_vec(64'hFFFF, 0);
    send_vec(64'h8000_0000_0000_0001, 2);
    send_vec(64'hF0F0, 1);

    // Reset pulsed while the second beat of 0x0F is on the bus.
    check("rst_pre_ready", 64'(bus.bv_ready), 64'(1));
    bus.bv       = 64'h0F;
    bus.bv_valid = 1'b1;
    @(negedge clk);
    bus.bv_valid  = 1'b0;
    bus.idx_ready = 1'b1;
    check("rst_beat0", 64'(bus.idx), 64'(0));
    @(negedge clk);
    check("rst_beat1", 64'(bus.idx), 64'(1));
    reset = 1'b1;
    #1;
    check("midrst_idx_valid", 64'(bus.idx_valid), 64'(0));
    check("midrst_bv_ready", 64'(bus.bv_ready), 64'(1));
    check("midrst_idx_last", 64'(bus.idx_last), 64'(0));
    @(negedge clk);
    reset         = 1'b0;
    bus.idx_ready = 1'b0;
    send_vec(64'h10, 0);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       v = 64'h0;
        1:       v = 64'h1 << $urandom_range(0, 63);
        2:       v = {$urandom, $urandom};
        3:       v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: v = 64'($urandom_range(0, 255));
      endcase
      send_vec(v, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got=running expected=done");
    $fatal(1, "watchdog expired");
  end

endmodule
